filtro_iir_df2: RTL and testbench



---
 rtl/filtro_pkg.sv | 55 +++++
 rtl/filtro_mac_sat.sv | 81 ++++++++
 rtl/filtro_iir_df2.sv | 120 ++++++++++++
 tb/tb_filtro_iir_df2.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filtro_pkg.sv
// Shared definitions for the filtro_iir_df2 biquad slice.
// Holds the default data/fraction widths, the FSM state encoding, the MAC
// operation encoding, the coefficient ROM index map and the helper that turns
// an FSM state into the ROM select it must drive.
package filtro_pkg;

  localparam int CANT_BITS_DEF = 25;
  localparam int FRAC_BITS_DEF = 14;

  // One state per MAC slot; W is the slot where the recursion result is taken.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_G,
    ST_A1,
    ST_A2,
    ST_W,
    ST_B0,
    ST_B1,
    ST_B2
  } state_t;

  // MAC operations: LOAD starts a new sum, ADD extends it, CLEAR zeroes it
  // while still presenting the old sum on the normalised output.
  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_ADD
  } mac_op_t;

  localparam logic [3:0] IDX_G    = 4'd0;
  localparam logic [3:0] IDX_A1   = 4'd1;
  localparam logic [3:0] IDX_A2   = 4'd2;
  localparam logic [3:0] IDX_NULL = 4'd3;
  localparam logic [3:0] IDX_B0   = 4'd5;
  localparam logic [3:0] IDX_B1   = 4'd6;
  localparam logic [3:0] IDX_B2   = 4'd7;

  // ROM select for each state; IDLE and W point at an entry that reads 0.
  function automatic logic [3:0] selForState(input state_t s);
    logic [3:0] sel;
    sel = IDX_NULL;
    case (s)
      ST_G:    sel = IDX_G;
      ST_A1:   sel = IDX_A1;
      ST_A2:   sel = IDX_A2;
      ST_B0:   sel = IDX_B0;
      ST_B1:   sel = IDX_B1;
      ST_B2:   sel = IDX_B2;
      default: sel = IDX_NULL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/filtro_mac_sat.sv
// Time-shared signed multiply-accumulate with normalisation and saturation.
// Build option: define IIR_ROUND_EN to round half up before the shift;
// without it the shift floors.
// Ports:
//   clk     system clock
//   reset   asynchronous active-high reset, clears the accumulator
//   i_op    HOLD / CLEAR / LOAD (acc = a*b) / ADD (acc += a*b)
//   i_a     signed operand (coefficient)
//   i_b     signed operand (sample or state)
//   o_norm  saturated (sum >>> FRAC) of the value the accumulator is
//           being given this cycle (or of the old sum for HOLD/CLEAR)
module filtro_mac_sat
  import filtro_pkg::*;
#(
  parameter int A_W  = 25,
  parameter int FRAC = 14
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     i_op,
  input  logic [A_W-1:0] i_a,
  input  logic [A_W-1:0] i_b,
  output logic [A_W-1:0] o_norm
);

  localparam int PROD_W = 2 * A_W;
  localparam int ACC_W  = 2 * A_W + 3;
  // One spare bit so the rounding offset can never overflow the sum.
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-A_W+1){1'b0}}, {(A_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-A_W+1){1'b1}}, {(A_W-1){1'b0}}};
`ifdef IIR_ROUND_EN
  localparam logic signed [SUM_W-1:0] ROUND_CONST = {{(SUM_W-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
`endif

  logic signed [PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]  w_sum;
  logic signed [SUM_W-1:0]  w_rounded;
  logic signed [SUM_W-1:0]  w_shifted;
  logic signed [ACC_W-1:0]  r_acc;

  // Form the new sum, then normalise it so the caller can capture w or y in
  // the same cycle the last product is added.
  always_comb begin
    w_prod = $signed(i_a) * $signed(i_b);
    case (i_op)
      OP_LOAD: w_sum = SUM_W'(w_prod);
      OP_ADD:  w_sum = SUM_W'(r_acc) + SUM_W'(w_prod);
      default: w_sum = SUM_W'(r_acc);
    endcase
`ifdef IIR_ROUND_EN
    w_rounded = w_sum + ROUND_CONST;
`else
    w_rounded = w_sum;
`endif
    w_shifted = w_rounded >>> FRAC;
    if (w_shifted > SAT_MAX) begin
      o_norm = SAT_MAX[A_W-1:0];
    end else if (w_shifted < SAT_MIN) begin
      o_norm = SAT_MIN[A_W-1:0];
    end else begin
      o_norm = w_shifted[A_W-1:0];
    end
  end

  // Accumulator register; LOAD and ADD both take the freshly formed sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc <= '0;
    end else begin
      case (i_op)
        OP_CLEAR: r_acc <= '0;
        OP_LOAD,
        OP_ADD:   r_acc <= w_sum[ACC_W-1:0];
        default:  r_acc <= r_acc;
      endcase
    end
  end

endmodule

// File: rtl/filtro_iir_df2.sv
// Sequential direct-form-II biquad (200 Hz high-pass ROM client).
// One MAC per cycle, eight cycles per sample:
//   w = sat(g*x + a1*w1 + a2*w2),  y = sat(b0*w + b1*w1 + b2*w2)
// Build option: IIR_ROUND_EN selects round-half-up normalisation (same timing).
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   start    sample strobe, only looked at in IDLE
//   x_in     signed input sample
//   cte      signed coefficient returned by the ROM for sel_cte
//   sel_cte  ROM coefficient select, decoded from the state
//   y_out    registered filtered sample
//   done     one-cycle pulse when y_out has been updated
//   busy     high whenever the FSM is not in IDLE
module filtro_iir_df2 #(
  parameter int cant_bits = filtro_pkg::CANT_BITS_DEF,
  parameter int FRAC_BITS = filtro_pkg::FRAC_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [cant_bits-1:0] x_in,
  input  logic [cant_bits-1:0] cte,
  output logic [3:0]           sel_cte,
  output logic [cant_bits-1:0] y_out,
  output logic                 done,
  output logic                 busy
);

  import filtro_pkg::*;

  state_t                 r_state;
  logic [cant_bits-1:0]   r_x;
  logic [cant_bits-1:0]   r_w;
  logic [cant_bits-1:0]   r_w1;
  logic [cant_bits-1:0]   r_w2;
  logic [cant_bits-1:0]   r_y;
  logic                   r_done;
  mac_op_t                w_op;
  logic [cant_bits-1:0]   w_operand;
  logic [cant_bits-1:0]   w_accNorm;

  // Pick the MAC operation and the data operand that pairs with the
  // coefficient the ROM is returning for this state.
  always_comb begin
    w_op      = OP_HOLD;
    w_operand = '0;
    case (r_state)
      ST_IDLE: w_op = start ? OP_CLEAR : OP_HOLD;
      ST_G:    begin w_op = OP_LOAD; w_operand = r_x;  end
      ST_A1:   begin w_op = OP_ADD;  w_operand = r_w1; end
      ST_A2:   begin w_op = OP_ADD;  w_operand = r_w2; end
      ST_W:    w_op = OP_CLEAR;
      ST_B0:   begin w_op = OP_LOAD; w_operand = r_w;  end
      ST_B1:   begin w_op = OP_ADD;  w_operand = r_w1; end
      ST_B2:   begin w_op = OP_ADD;  w_operand = r_w2; end
      default: w_op = OP_HOLD;
    endcase
  end

  filtro_mac_sat #(
    .A_W  (cant_bits),
    .FRAC (FRAC_BITS)
  ) u_mac (
    .clk    (clk),
    .reset  (reset),
    .i_op   (w_op),
    .i_a    (cte),
    .i_b    (w_operand),
    .o_norm (w_accNorm)
  );

  // Sequencer: walks the seven MAC slots, captures w in W and y plus the
  // delay-line shift on leaving B2. A start seen in any non-IDLE state is
  // simply not looked at.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x     <= '0;
      r_w     <= '0;
      r_w1    <= '0;
      r_w2    <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_x     <= x_in;
            r_state <= ST_G;
          end
        end
        ST_G:  r_state <= ST_A1;
        ST_A1: r_state <= ST_A2;
        ST_A2: r_state <= ST_W;
        ST_W: begin
          r_w     <= w_accNorm;
          r_state <= ST_B0;
        end
        ST_B0: r_state <= ST_B1;
        ST_B1: r_state <= ST_B2;
        ST_B2: begin
          r_y     <= w_accNorm;
          r_w2    <= r_w1;
          r_w1    <= r_w;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sel_cte = selForState(r_state);
  assign y_out   = r_y;
  assign done    = r_done;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_filtro_iir_df2.sv
`timescale 1ns/1ps
// Directed bench for filtro_iir_df2: impulse, timing, saturation, DC
// rejection against a behavioural model, and control edge cases.
module tb_filtro_iir_df2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [24:0] x_in;
  logic [24:0] cte;
  logic [3:0]  sel_cte;
  logic [24:0] y_out;
  logic        done;
  logic        busy;

  int assertCount = 0;
  int failCount   = 0;
  int timeouts    = 0;

  // Coefficient ROM contents (Q14, 0x4000 = 1.0).
  localparam logic [24:0] C_G  = 25'h0004000;
  localparam logic [24:0] C_A1 = 25'h0007D71;
  localparam logic [24:0] C_A2 = 25'h1FFC287;
  localparam logic [24:0] C_B0 = 25'h0004000;
  localparam logic [24:0] C_B1 = 25'h1FF8000;
  localparam logic [24:0] C_B2 = 25'h0004000;

  longint mW1, mW2;

  always #5 clk = ~clk;

  // Combinational ROM driven by the DUT select.
  always_comb begin
    cte = '0;
    case (sel_cte)
      4'd0: cte = C_G;
      4'd1: cte = C_A1;
      4'd2: cte = C_A2;
      4'd5: cte = C_B0;
      4'd6: cte = C_B1;
      4'd7: cte = C_B2;
      default: cte = '0;
    endcase
  end

  filtro_iir_df2 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .x_in    (x_in),
    .cte     (cte),
    .sel_cte (sel_cte),
    .y_out   (y_out),
    .done    (done),
    .busy    (busy)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic longint sx(input logic [24:0] v);
    return longint'($signed(v));
  endfunction

  // Behavioural normalisation: shift with optional round-half-up, then clamp.
  function automatic longint normModel(input longint a);
    longint s;
`ifdef IIR_ROUND_EN
    a = a + 64'sd8192;
`endif
    s = a >>> 14;
    if (s > 64'sd16777215) s = 64'sd16777215;
    if (s < -64'sd16777216) s = -64'sd16777216;
    return s;
  endfunction

  task automatic modelStep(input logic [24:0] x, output logic [24:0] yExp);
    longint w, y;
    w = normModel(sx(C_G) * sx(x) + sx(C_A1) * mW1 + sx(C_A2) * mW2);
    y = normModel(sx(C_B0) * w + sx(C_B1) * mW1 + sx(C_B2) * mW2);
    mW2 = mW1;
    mW1 = w;
    yExp = y[24:0];
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mW1 = 0;
    mW2 = 0;
  endtask

  // Issue one sample and wait (bounded) for its done pulse.
  task automatic applyStimulus(input logic [24:0] x, output logic [24:0] y);
    bit gotDone;
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    @(negedge clk);
    start = 1'b0;
    x_in  = '0;
    gotDone = 1'b0;
    for (int i = 0; i < 20 && !gotDone; i++) begin
      if (done) gotDone = 1'b1;
      else @(negedge clk);
    end
    if (!gotDone) begin
      timeouts++;
      $display("[TB] FAIL done_wait: got no done, expected done within 20 cycles");
    end
    y = y_out;
  endtask

  task automatic waitDone();
    bit gotDone;
    gotDone = 1'b0;
    for (int i = 0; i < 20 && !gotDone; i++) begin
      if (done) gotDone = 1'b1;
      else @(negedge clk);
    end
    if (!gotDone) begin
      timeouts++;
      $display("[TB] FAIL done_wait: got no done, expected done within 20 cycles");
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [24:0] y;
    logic [24:0] yExp;
    logic [3:0]  expSel [7];
    logic signed [24:0] ys;
    int busyCycles, doneEarly, dcMis, doneSeen, yAbs;

    expSel = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7};
    reset = 1'b1;
    start = 1'b0;
    x_in  = '0;
    mW1 = 0;
    mW2 = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("rst_y", 32'(y_out), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_sel", 32'(sel_cte), 32'h3);

    // Impulse sample 1 with cycle-by-cycle timing checks.
    start = 1'b1;
    x_in  = 25'h0004000;
    @(negedge clk);
    start = 1'b0;
    x_in  = '0;
    busyCycles = 0;
    doneEarly  = 0;
    for (int k = 0; k < 7; k++) begin
      checkOutput($sformatf("sel_%0d", k), 32'(sel_cte), 32'(expSel[k]));
      if (busy) busyCycles++;
      if (done) doneEarly++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 32'(busyCycles), 32'd7);
    checkOutput("done_early", 32'(doneEarly), 32'd0);
    checkOutput("done_pulse", 32'(done), 32'h1);
    checkOutput("busy_at_done", 32'(busy), 32'h0);
    checkOutput("impulse_y1", 32'(y_out), 32'h0004000);

    // Back-to-back: start accepted in the done cycle.
    start = 1'b1;
    x_in  = '0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done_width", 32'(done), 32'h0);
    checkOutput("b2b_busy", 32'(busy), 32'h1);
    checkOutput("b2b_sel", 32'(sel_cte), 32'h0);
    waitDone();
    checkOutput("impulse_y2", 32'(y_out), 32'h1FFFD71);
    @(negedge clk);
    checkOutput("y_hold", 32'(y_out), 32'h1FFFD71);

    // Saturation: w and y clamp, no wrap.
    doReset();
    applyStimulus(25'h0FFFFFF, y);
    checkOutput("sat_y1", 32'(y), 32'h0FFFFFF);
    applyStimulus(25'h0FFFFFF, y);
    checkOutput("sat_y2", 32'(y), 32'h1000001);

    // DC rejection tracked against the behavioural model.
    doReset();
    dcMis = 0;
    for (int n = 0; n < 400; n++) begin
      applyStimulus(25'h0001000, y);
      modelStep(25'h0001000, yExp);
      if (n == 0) checkOutput("dc_first", 32'(y), 32'h0001000);
      if (y !== yExp) dcMis++;
    end
    checkOutput("dc_track", 32'(dcMis), 32'd0);
    checkOutput("dc_final_model", 32'(y), 32'(yExp));
    ys = $signed(y);
    yAbs = (ys < 0) ? -int'(ys) : int'(ys);
    checkOutput("dc_small", 32'(yAbs < 16), 32'h1);

    // start during B0 is ignored.
    doReset();
    @(negedge clk);
    start = 1'b1;
    x_in  = 25'h0004000;
    @(negedge clk);
    start = 1'b0;
    x_in  = '0;
    repeat (4) @(negedge clk);
    checkOutput("in_b0_sel", 32'(sel_cte), 32'h5);
    start = 1'b1;
    x_in  = 25'h0FFFFFF;
    @(negedge clk);
    start = 1'b0;
    x_in  = '0;
    waitDone();
    checkOutput("b0_ignore_y", 32'(y_out), 32'h0004000);
    @(negedge clk);
    checkOutput("b0_ignore_busy", 32'(busy), 32'h0);
    applyStimulus(25'h0, y);
    checkOutput("b0_ignore_y2", 32'(y), 32'h1FFFD71);

    // Reset asserted in B1 aborts the sample.
    @(negedge clk);
    start = 1'b1;
    x_in  = 25'h0004000;
    @(negedge clk);
    start = 1'b0;
    x_in  = '0;
    repeat (5) @(negedge clk);
    checkOutput("in_b1_sel", 32'(sel_cte), 32'h6);
    reset = 1'b1;
    #1;
    checkOutput("midrst_y", 32'(y_out), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_sel", 32'(sel_cte), 32'h3);
    @(negedge clk);
    reset = 1'b0;
    mW1 = 0;
    mW2 = 0;
    doneSeen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) doneSeen++;
      @(negedge clk);
    end
    checkOutput("midrst_no_done", 32'(doneSeen), 32'd0);
    applyStimulus(25'h0004000, y);
    checkOutput("post_rst_y1", 32'(y), 32'h0004000);
    applyStimulus(25'h0, y);
    checkOutput("post_rst_y2", 32'(y), 32'h1FFFD71);

    checkOutput("timeouts", 32'(timeouts), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
